// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: button edge detection, cursor movement, piece
// placement, turn alternation and win/draw detection for the VGA grid renderer.
module ttt_game_ctrl #(
  parameter int START_CELL   = 0,
  parameter bit FIRST_PLAYER = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick,
  input  logic        btnL,
  input  logic        btnR,
  input  logic        btnU,
  input  logic        btnD,
  input  logic        btnC,
  output logic [8:0]  cursor,
  output logic [17:0] board,
  output logic        turn,
  output logic [1:0]  game_state,
  output logic [1:0]  winner,
  output logic [8:0]  win_line,
  output logic        illegal
);

  typedef enum logic [2:0] {S_IDLE, S_PLAY, S_CHECK, S_WIN, S_DRAW} state_t;

  localparam logic [3:0] START_IDX    = 4'(START_CELL);
  localparam logic [8:0] START_ONEHOT = 9'b1 << START_CELL;

  state_t      state;
  logic [4:0]  btn_now;
  logic [4:0]  btn_prev;
  logic [4:0]  press;
  logic [3:0]  cur_idx;
  logic [3:0]  next_idx;
  logic [1:0]  mover;
  logic [1:0]  cell_at_cursor;
  logic [8:0]  owned;

  function automatic logic [8:0] line_mask(input int k);
    case (k)
      0:       return 9'b000000111;
      1:       return 9'b000111000;
      2:       return 9'b111000000;
      3:       return 9'b001001001;
      4:       return 9'b010010010;
      5:       return 9'b100100100;
      6:       return 9'b100010001;
      7:       return 9'b001010100;
      default: return 9'b000000000;
    endcase
  endfunction

  // Union of every complete line held by `who`; zero when no line is complete.
  function automatic logic [8:0] owned_cells(input logic [17:0] b, input logic [1:0] who);
    logic [8:0] mine;
    logic [8:0] acc;
    acc = '0;
    for (int i = 0; i < 9; i++) mine[i] = (b[2*i +: 2] == who);
    for (int k = 0; k < 8; k++)
      if ((mine & line_mask(k)) == line_mask(k)) acc = acc | line_mask(k);
    return acc;
  endfunction

  function automatic logic board_full(input logic [17:0] b);
    logic full;
    full = 1'b1;
    for (int i = 0; i < 9; i++) if (b[2*i +: 2] == 2'b00) full = 1'b0;
    return full;
  endfunction

  // Cursor rotation mod 9; L > R > U > D when several are pressed together.
  function automatic logic [3:0] step_cursor(input logic [3:0] idx, input logic [3:0] p);
    if (p[3])      return (idx == 4'd0) ? 4'd8 : idx - 4'd1;
    else if (p[2]) return (idx == 4'd8) ? 4'd0 : idx + 4'd1;
    else if (p[1]) return (idx < 4'd3)  ? idx + 4'd6 : idx - 4'd3;
    else if (p[0]) return (idx > 4'd5)  ? idx - 4'd6 : idx + 4'd3;
    else           return idx;
  endfunction

  assign btn_now        = {btnC, btnL, btnR, btnU, btnD};
  assign press          = tick ? (btn_now & ~btn_prev) : 5'b00000;
  assign next_idx       = step_cursor(cur_idx, press[3:0]);
  assign mover          = turn ? 2'b10 : 2'b01;
  assign cell_at_cursor = board[{cur_idx, 1'b0} +: 2];
  assign owned          = owned_cells(board, mover);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      btn_prev   <= '0;
      cur_idx    <= START_IDX;
      cursor     <= START_ONEHOT;
      board      <= '0;
      turn       <= FIRST_PLAYER;
      game_state <= 2'b00;
      winner     <= 2'b00;
      win_line   <= '0;
      illegal    <= 1'b0;
    end else begin
      illegal <= 1'b0;
      if (tick) btn_prev <= btn_now;
      case (state)
        S_IDLE: begin
          if (press[4]) begin
            state      <= S_PLAY;
            game_state <= 2'b01;
            turn       <= FIRST_PLAYER;
            cur_idx    <= START_IDX;
            cursor     <= START_ONEHOT;
          end
        end
        S_PLAY: begin
          if (press[4]) begin
            if (cell_at_cursor != 2'b00) begin
              illegal <= 1'b1;
            end else begin
              board[{cur_idx, 1'b0} +: 2] <= mover;
              state <= S_CHECK;
            end
          end else if (|press[3:0]) begin
            cur_idx <= next_idx;
            cursor  <= 9'b1 << next_idx;
          end
        end
        // The just-written piece is already in board, so only the mover can have won.
        S_CHECK: begin
          if (|owned) begin
            state      <= S_WIN;
            game_state <= 2'b10;
            winner     <= mover;
            win_line   <= owned;
          end else if (board_full(board)) begin
            state      <= S_DRAW;
            game_state <= 2'b11;
          end else begin
            state <= S_PLAY;
            turn  <= ~turn;
          end
        end
        S_WIN, S_DRAW: begin
          if (press[4]) begin
            state      <= S_IDLE;
            game_state <= 2'b00;
            board      <= '0;
            winner     <= 2'b00;
            win_line   <= '0;
            turn       <= FIRST_PLAYER;
            cur_idx    <= START_IDX;
            cursor     <= START_ONEHOT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Scoreboard bench for ttt_game_ctrl: a behavioural game model pushes the
// expected output snapshot for every tick; each scenario pops and compares.
module tb_ttt_game_ctrl;

  localparam int SC = 0;
  localparam bit FP = 1'b0;
  localparam logic [4:0] BC = 5'b10000, BL = 5'b01000, BR = 5'b00100,
                         BU = 5'b00010, BD = 5'b00001, B0 = 5'b00000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick = 1'b0;
  logic        btnL = 1'b0, btnR = 1'b0, btnU = 1'b0, btnD = 1'b0, btnC = 1'b0;
  logic [8:0]  cursor;
  logic [17:0] board;
  logic        turn;
  logic [1:0]  game_state;
  logic [1:0]  winner;
  logic [8:0]  win_line;
  logic        illegal;

  ttt_game_ctrl #(.START_CELL(SC), .FIRST_PLAYER(FP)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick),
    .btnL(btnL), .btnR(btnR), .btnU(btnU), .btnD(btnD), .btnC(btnC),
    .cursor(cursor), .board(board), .turn(turn), .game_state(game_state),
    .winner(winner), .win_line(win_line), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  logic [41:0] exp_q[$];
  logic [41:0] want;
  logic [4:0]  acts[$];
  int          plan_cur;

  // Reference model state
  int          m_cur;
  logic [17:0] m_board;
  logic        m_turn;
  logic [1:0]  m_gs, m_win;
  logic [8:0]  m_wl;
  logic        m_ill, m_toggle;
  logic [4:0]  m_prev;

  function automatic logic [41:0] obs();
    return {cursor, board, turn, game_state, winner, win_line, illegal};
  endfunction

  function automatic logic [41:0] expv();
    logic [8:0] c;
    c = 9'b1 << m_cur;
    return {c, m_board, m_turn, m_gs, m_win, m_wl, m_ill};
  endfunction

  task automatic model_reset();
    m_cur = SC; m_board = '0; m_turn = FP; m_gs = 2'b00; m_win = 2'b00;
    m_wl = '0; m_ill = 1'b0; m_toggle = 1'b0; m_prev = '0;
  endtask

  // Advance the model by one tick, queue its prediction, then drive the tick.
  task automatic tick_b(input logic [4:0] b);
    logic [4:0] p;
    if (m_toggle) begin m_turn = ~m_turn; m_toggle = 1'b0; end
    m_ill = 1'b0;
    p = b & ~m_prev;
    m_prev = b;
    case (m_gs)
      2'b00: if (p[4]) begin m_gs = 2'b01; m_turn = FP; m_cur = SC; end
      2'b01: begin
        if (p[4]) begin
          if (m_board[2*m_cur +: 2] != 2'b00) m_ill = 1'b1;
          else begin m_board[2*m_cur +: 2] = m_turn ? 2'b10 : 2'b01; m_toggle = 1'b1; end
        end
        else if (p[3]) m_cur = (m_cur + 8) % 9;
        else if (p[2]) m_cur = (m_cur + 1) % 9;
        else if (p[1]) m_cur = (m_cur + 6) % 9;
        else if (p[0]) m_cur = (m_cur + 3) % 9;
      end
      default: if (p[4]) begin
        m_gs = 2'b00; m_board = '0; m_win = 2'b00; m_wl = '0; m_cur = SC; m_turn = FP;
      end
    endcase
    exp_q.push_back(expv());
    @(negedge clk);
    {btnC, btnL, btnR, btnU, btnD} = b;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic plan_place(input int target);
    while (plan_cur != target) begin
      acts.push_back(BR); acts.push_back(B0);
      plan_cur = (plan_cur + 1) % 9;
    end
    acts.push_back(BC); acts.push_back(B0);
  endtask

  task automatic do_reset();
    {btnC, btnL, btnR, btnU, btnD} = B0;
    tick = 1'b0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    plan_cur = SC;
  endtask

  task automatic test_reset();
    model_reset();
    exp_q.push_back(expv());
    @(negedge clk);
    want = exp_q.pop_front();
    n_total++;
    if (obs() !== want) begin n_bad++; $display("FAIL reset_state: got=%h want=%h", obs(), want); end
    btnC = 1'b1; tick = 1'b1;
    exp_q.push_back(expv());
    @(negedge clk);
    tick = 1'b0; btnC = 1'b0;
    want = exp_q.pop_front();
    n_total++;
    if (obs() !== want) begin n_bad++; $display("FAIL reset_holds_on_press: got=%h want=%h", obs(), want); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_no_repeat();
    do_reset();
    acts = '{BC, B0, BR, BR, BR, BR, BR, B0};
    foreach (acts[i]) begin
      tick_b(acts[i]);
      want = exp_q.pop_front();
      n_total++;
      if (obs() !== want) begin n_bad++; $display("FAIL no_repeat step %0d: got=%h want=%h", i, obs(), want); end
    end
    acts.delete();
  endtask

  task automatic test_moves();
    acts = '{BL, B0, BL, B0, BU, B0, BU, B0, BL, B0, BU, B0, BD, B0, BL, B0};
    foreach (acts[i]) begin
      tick_b(acts[i]);
      want = exp_q.pop_front();
      n_total++;
      if (obs() !== want) begin n_bad++; $display("FAIL moves step %0d: got=%h want=%h", i, obs(), want); end
    end
    acts.delete();
    n_total++;
    if (cursor !== 9'b000000001) begin n_bad++; $display("FAIL moves_end_cursor: got=%b want=%b", cursor, 9'b000000001); end
  endtask

  task automatic test_win();
    do_reset();
    acts = '{BC, B0};
    plan_place(0); plan_place(3); plan_place(1); plan_place(4); plan_place(2);
    void'(acts.pop_back());
    foreach (acts[i]) begin
      tick_b(acts[i]);
      want = exp_q.pop_front();
      n_total++;
      if (obs() !== want) begin n_bad++; $display("FAIL win step %0d: got=%h want=%h", i, obs(), want); end
    end
    acts.delete();
    @(negedge clk);
    m_toggle = 1'b0; m_gs = 2'b10; m_win = 2'b01; m_wl = 9'b000000111;
    exp_q.push_back(expv());
    want = exp_q.pop_front();
    n_total++;
    if (obs() !== want) begin n_bad++; $display("FAIL win_at_t2: got=%h want=%h", obs(), want); end
    acts = '{B0, BL, B0, BR, B0, BU, B0, BC, B0};
    foreach (acts[i]) begin
      tick_b(acts[i]);
      want = exp_q.pop_front();
      n_total++;
      if (obs() !== want) begin n_bad++; $display("FAIL win_frozen step %0d: got=%h want=%h", i, obs(), want); end
    end
    acts.delete();
  endtask

  task automatic test_illegal();
    do_reset();
    acts = '{BC, B0};
    plan_place(4);
    acts.push_back(BC); acts.push_back(B0);
    acts.push_back(BR); acts.push_back(B0);
    foreach (acts[i]) begin
      tick_b(acts[i]);
      want = exp_q.pop_front();
      n_total++;
      if (obs() !== want) begin n_bad++; $display("FAIL illegal step %0d: got=%h want=%h", i, obs(), want); end
    end
    acts.delete();
  endtask

  task automatic test_draw();
    do_reset();
    acts = '{BC, B0};
    plan_place(0); plan_place(1); plan_place(2); plan_place(4); plan_place(3);
    plan_place(5); plan_place(7); plan_place(6); plan_place(8);
    void'(acts.pop_back());
    foreach (acts[i]) begin
      tick_b(acts[i]);
      want = exp_q.pop_front();
      n_total++;
      if (obs() !== want) begin n_bad++; $display("FAIL draw step %0d: got=%h want=%h", i, obs(), want); end
    end
    acts.delete();
    @(negedge clk);
    m_toggle = 1'b0; m_gs = 2'b11; m_win = 2'b00; m_wl = '0;
    exp_q.push_back(expv());
    want = exp_q.pop_front();
    n_total++;
    if (obs() !== want) begin n_bad++; $display("FAIL draw_at_t2: got=%h want=%h", obs(), want); end
    acts = '{B0, BC, B0};
    foreach (acts[i]) begin
      tick_b(acts[i]);
      want = exp_q.pop_front();
      n_total++;
      if (obs() !== want) begin n_bad++; $display("FAIL draw_new_game step %0d: got=%h want=%h", i, obs(), want); end
    end
    acts.delete();
  endtask

  task automatic test_reset_mid();
    do_reset();
    acts = '{BC, B0};
    plan_place(2);
    acts.push_back(BD); acts.push_back(B0);
    foreach (acts[i]) begin
      tick_b(acts[i]);
      want = exp_q.pop_front();
      n_total++;
      if (obs() !== want) begin n_bad++; $display("FAIL mid_setup step %0d: got=%h want=%h", i, obs(), want); end
    end
    acts.delete();
    #2 reset_n = 1'b0;
    model_reset();
    exp_q.push_back(expv());
    #1;
    want = exp_q.pop_front();
    n_total++;
    if (obs() !== want) begin n_bad++; $display("FAIL async_reset: got=%h want=%h", obs(), want); end
    @(negedge clk);
    reset_n = 1'b1;
    acts = '{BL | BC, B0, BL | BC, B0, BL | BR, B0, BR | BU, B0, BU | BD, B0};
    foreach (acts[i]) begin
      tick_b(acts[i]);
      want = exp_q.pop_front();
      n_total++;
      if (obs() !== want) begin n_bad++; $display("FAIL priority step %0d: got=%h want=%h", i, obs(), want); end
    end
    acts.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_no_repeat();
    test_moves();
    test_win();
    test_illegal();
    test_draw();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
